imem_responder: RTL and testbench

Memory-side responder for the instruction-cache refill interface: serves one word per request from an internal instruction RAM with programmable access latency. Sits between the fetch unit's cache-miss/refill port (`miss_cache`, `ram_address`) and the program loader, returning `mem_word` with a one-cycle `word_ready` strobe. Also provides a write port so the testbench or boot loader can preload program images.

---
 rtl/imem_responder.sv | 156 +++++++++++++++
 tb/tb_imem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Memory-side responder for the instruction-cache refill port. A request
//   seen on miss_cache in IDLE is captured, held for LATENCY cycles, and
//   answered with one word from the internal instruction RAM together with
//   a single-cycle word_ready strobe. A loader port writes the RAM at any
//   time without stalling the request FSM.
//
//   Optional feature macro: IMEM_ADDR_CHECK_EN
//     defined   : misaligned addresses or addresses above the RAM range are
//                 flagged; such requests return a NOP word with addr_err=1.
//     undefined : no check; addresses alias modulo the RAM depth and
//                 addr_err is always 0.
//
// Ports
//   clk          in   clock, all state on rising edge
//   nrst         in   asynchronous active-low reset
//   miss_cache   in   refill request level from fetch unit
//   ram_address  in   byte address of requested word   [ADDR_W]
//   ld_en        in   loader write enable
//   ld_addr      in   loader word index                [DEPTH_LOG]
//   ld_data      in   loader write data                [MEM_WORD]
//   mem_word     out  returned word, 0 unless word_ready [MEM_WORD]
//   word_ready   out  one-cycle strobe: mem_word valid
//   busy         out  high while a request is in WAIT or RESP
//   addr_err     out  address error flag, valid with word_ready
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int unsigned MEM_WORD  = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH_LOG = 10,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 miss_cache,
  input  logic [ADDR_W-1:0]    ram_address,
  input  logic                 ld_en,
  input  logic [DEPTH_LOG-1:0] ld_addr,
  input  logic [MEM_WORD-1:0]  ld_data,
  output logic [MEM_WORD-1:0]  mem_word,
  output logic                 word_ready,
  output logic                 busy,
  output logic                 addr_err
);

  localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [MEM_WORD-1:0] NOP_WORD = MEM_WORD'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q,      state_d;
  logic [3:0]             cnt_q,        cnt_d;
  logic [DEPTH_LOG-1:0]   idx_q,        idx_d;
  logic                   err_q,        err_d;
  logic [MEM_WORD-1:0]    mem_word_q,   mem_word_d;
  logic                   word_ready_q, word_ready_d;
  logic                   busy_q,       busy_d;
  logic                   addr_err_q,   addr_err_d;

  logic [MEM_WORD-1:0]    mem [2**DEPTH_LOG];
  logic                   req_err;

`ifdef IMEM_ADDR_CHECK_EN
  assign req_err = (|ram_address[1:0]) | (|ram_address[ADDR_W-1:DEPTH_LOG+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_address[ADDR_W-1:DEPTH_LOG+2], ram_address[1:0]};
  assign req_err          = 1'b0;
`endif

  // RAM is not reset. The FSM reads it through always_comb from the
  // pre-edge contents, so a same-edge loader write is seen only by later
  // requests (read-before-write).
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Outputs are registered: the _d values computed here become visible in
  // the cycle after the edge that moves the FSM into the matching state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    err_d        = err_q;
    mem_word_d   = '0;
    word_ready_d = 1'b0;
    busy_d       = 1'b0;
    addr_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_cache) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          idx_d   = ram_address[DEPTH_LOG+1:2];
          err_d   = req_err;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!miss_cache) begin
          // abort takes priority over a counter that just reached zero
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d      = S_RESP;
          word_ready_d = 1'b1;
          busy_d       = 1'b1;
          addr_err_d   = err_q;
          mem_word_d   = err_q ? NOP_WORD : mem[idx_q];
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      mem_word_q   <= '0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      mem_word_q   <= mem_word_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign mem_word   = mem_word_q;
  assign word_ready = word_ready_q;
  assign busy       = busy_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Scoreboard bench for imem_responder. The driver issues refill requests
//   (directed cases, then random ones with random loader traffic) and pushes
//   the expected word, error flag and strobe cycle into a queue. A monitor on
//   the falling clock edge pops and compares whenever word_ready is seen,
//   and checks busy / idle output values every cycle.
//   Honours IMEM_ADDR_CHECK_EN in the reference model.
// ---------------------------------------------------------------------------
module tb_imem_responder;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        nrst;
  logic        miss_cache;
  logic [31:0] ram_address;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_word;
  logic        word_ready;
  logic        busy;
  logic        addr_err;

  imem_responder #(
    .MEM_WORD (32),
    .ADDR_W   (32),
    .DEPTH_LOG(10),
    .LATENCY  (LAT)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .miss_cache (miss_cache),
    .ram_address(ram_address),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .mem_word   (mem_word),
    .word_ready (word_ready),
    .busy       (busy),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_model [1024];
  int          cyc        = 0;
  int          vectors    = 0;
  int          miscompares = 0;
  logic        exp_busy   = 1'b0;
  bit          ld_rand    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word index is the byte address divided by four, folded
  // into the 1024-word RAM; errored requests return a NOP.
  function automatic logic model_err(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return (a % 4 != 0) || (a >= 32'd4096);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned idx;
    idx = (a / 4) % 1024;
    if (model_err(a)) return 32'h0000_0013;
    return mem_model[idx];
  endfunction

  // One clock edge: mirror any loader write into the model, then optionally
  // schedule random loader traffic for the next edge.
  task automatic step();
    @(posedge clk);
    if (ld_en) mem_model[ld_addr] = ld_data;
    cyc++;
    #1;
    if (ld_rand) begin
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 10'($urandom_range(0, 63));
      ld_data = $urandom;
    end else begin
      ld_en = 1'b0;
    end
  endtask

  // drop_at = 0 : hold the request through to the strobe
  // drop_at = k : miss_cache low when edge k after capture samples it
  // keep        : leave miss_cache high after the strobe (back-to-back)
  // coll        : loader writes coll_data to the requested index on the
  //               same edge the RAM is read
  task automatic do_req(input logic [31:0] a, input int unsigned drop_at,
                        input bit keep, input bit coll, input logic [31:0] coll_data);
    exp_t e;
    miss_cache  = 1'b1;
    ram_address = a;
    step();                                   // capture edge
    exp_busy = 1'b1;
    for (int unsigned k = 1; k <= LAT; k++) begin
      if (drop_at == k) miss_cache = 1'b0;
      else if (k == LAT) begin
        e.data = model_word(a);
        e.err  = model_err(a);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        if (coll) begin
          ld_en   = 1'b1;
          ld_addr = 10'((a / 4) % 1024);
          ld_data = coll_data;
        end
      end
      step();
      if (drop_at == k) begin
        exp_busy = 1'b0;
        return;
      end
    end
    if (!keep) miss_cache = 1'b0;
    step();                                   // RESP -> IDLE
    exp_busy = 1'b0;
  endtask

  // Monitor: scoreboard compare on strobe, idle/busy checks every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (word_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 32'(word_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("mem_word", mem_word, e.data);
        chk("addr_err", 32'(addr_err), 32'(e.err));
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_strobe", 32'(word_ready), 32'd1);
      end
      chk("idle_mem_word", mem_word, 32'd0);
      chk("idle_addr_err", 32'(addr_err), 32'd0);
    end
    chk("busy", 32'(busy), 32'(exp_busy));
  end

  initial begin
    logic [31:0] a;
    int unsigned drop;
    bit          keep;

    nrst        = 1'b1;
    miss_cache  = 1'b0;
    ram_address = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;

    // reset state
    #1 nrst = 1'b0;
    #1;
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_mem_word",   mem_word,        32'd0);
    chk("rst_addr_err",   32'(addr_err),   32'd0);
    step();
    step();
    nrst = 1'b1;

    // preload words 0..63
    for (int unsigned i = 0; i < 64; i++) begin
      ld_en   = 1'b1;
      ld_addr = 10'(i);
      ld_data = (i == 5) ? 32'hDEAD_BEEF : $urandom;
      step();
    end

    // single request to word 5
    do_req(32'h14, 0, 1'b0, 1'b0, '0);
    step();

    // four-word refill from 0x40, address advanced on each strobe
    for (int unsigned i = 0; i < 4; i++)
      do_req(32'h40 + 32'(4 * i), 0, (i != 3), 1'b0, '0);
    step();

    // drop while the counter is at 1, then drop on the edge it reaches 0
    do_req(32'h20, (LAT > 1) ? LAT - 1 : 1, 1'b0, 1'b0, '0);
    step();
    do_req(32'h24, LAT, 1'b0, 1'b0, '0);
    step();

    // loader write colliding with the RAM read of the same index
    do_req(32'h14, 0, 1'b0, 1'b1, 32'h1234_5678);
    step();
    do_req(32'h14, 0, 1'b0, 1'b0, '0);
    step();

    // asynchronous reset mid-WAIT
    miss_cache  = 1'b1;
    ram_address = 32'h30;
    step();
    exp_busy = 1'b1;
    step();
    #2 nrst = 1'b0;
    #1;
    chk("midrst_word_ready", 32'(word_ready), 32'd0);
    chk("midrst_busy",       32'(busy),       32'd0);
    chk("midrst_mem_word",   mem_word,        32'd0);
    chk("midrst_addr_err",   32'(addr_err),   32'd0);
    exp_busy   = 1'b0;
    miss_cache = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
    do_req(32'h30, 0, 1'b0, 1'b0, '0);
    step();

    // misaligned address
    do_req(32'h16, 0, 1'b0, 1'b0, '0);
    step();
    // address above the RAM range
    do_req(32'h0000_1014, 0, 1'b0, 1'b0, '0);
    step();

    // random traffic with concurrent loader writes
    ld_rand = 1'b1;
    for (int unsigned t = 0; t < 80; t++) begin
      a = 32'($urandom_range(0, 63)) * 4;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1000)) << 12);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0;
      keep = ($urandom_range(0, 1) == 1);
      do_req(a, drop, keep, ($urandom_range(0, 7) == 0), $urandom);
      if (drop != 0 || !keep) begin
        miss_cache = 1'b0;
        for (int unsigned j = $urandom_range(0, 2); j > 0; j--) step();
      end
    end
    ld_rand    = 1'b0;
    miss_cache = 1'b0;
    for (int unsigned i = 0; i < 6; i++) step();
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
